// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters decoded into registered blank, sync,
// coordinate and frame markers, with a shadowed timing update taken at the frame boundary.
module video_timing_gen #(
    parameter int CW     = 12,
    parameter int HACT   = 800,
    parameter int HFRONT = 40,
    parameter int HSYNC  = 128,
    parameter int HBACK  = 88,
    parameter int VACT   = 480,
    parameter int VFRONT = 10,
    parameter int VSYNC  = 2,
    parameter int VBACK  = 33,
    parameter bit HPOL   = 1'b1,
    parameter bit VPOL   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [4*CW-1:0] cfg_h,
    input  logic [4*CW-1:0] cfg_v,
    output logic            blank,
    output logic            hsync,
    output logic            vsync,
    output logic [CW-1:0]   x,
    output logic [CW-1:0]   y,
    output logic            sof,
    output logic            eol,
    output logic [15:0]     frame_cnt
);

    typedef struct packed {
        logic [CW-1:0] act;
        logic [CW-1:0] front;
        logic [CW-1:0] sync;
        logic [CW-1:0] back;
    } timing_t;

    localparam timing_t H_INIT = '{CW'(HACT), CW'(HFRONT), CW'(HSYNC), CW'(HBACK)};
    localparam timing_t V_INIT = '{CW'(VACT), CW'(VFRONT), CW'(VSYNC), CW'(VBACK)};

    // Running sum with a carry bit per step so any overflow of the total is caught.
    function automatic logic cfg_ok(input timing_t t);
        logic [CW:0] s;
        logic        ovf;
        s   = {1'b0, t.act} + {1'b0, t.front};
        ovf = s[CW];
        s   = {1'b0, s[CW-1:0]} + {1'b0, t.sync};
        ovf = ovf | s[CW];
        s   = {1'b0, s[CW-1:0]} + {1'b0, t.back};
        ovf = ovf | s[CW];
        return (t.act != '0) && (t.sync != '0) && !ovf;
    endfunction

    timing_t       h_live_q, v_live_q, sh_h_q, sh_v_q;
    logic          pend_q, ready_q, seen_sof_q;
    logic [CW-1:0] hcnt_q, vcnt_q, hcnt_d, vcnt_d;
    logic          blank_q, hsync_q, vsync_q, sof_q, eol_q;
    logic [CW-1:0] x_q, y_q;
    logic [15:0]   fcnt_q;

    logic [CW:0]   h_ss, h_se, h_tot, v_ss, v_se, v_tot, hcnt_x, vcnt_x;
    logic          h_last, v_last, capture, apply, active, hs_on, vs_on, is_sof, is_eol;

    assign hcnt_x = {1'b0, hcnt_q};
    assign vcnt_x = {1'b0, vcnt_q};
    assign h_ss   = {1'b0, h_live_q.act} + {1'b0, h_live_q.front};
    assign h_se   = h_ss + {1'b0, h_live_q.sync};
    assign h_tot  = h_se + {1'b0, h_live_q.back};
    assign v_ss   = {1'b0, v_live_q.act} + {1'b0, v_live_q.front};
    assign v_se   = v_ss + {1'b0, v_live_q.sync};
    assign v_tot  = v_se + {1'b0, v_live_q.back};

    assign h_last  = (hcnt_x == h_tot - (CW+1)'(1));
    assign v_last  = (vcnt_x == v_tot - (CW+1)'(1));
    assign capture = cfg_valid && !pend_q;
    assign apply   = pend_q && enable && h_last && v_last;

    always_comb begin
        hcnt_d = hcnt_q + CW'(1);
        vcnt_d = vcnt_q;
        if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : vcnt_q + CW'(1);
        end
    end

    always_comb begin
        active = (hcnt_q < h_live_q.act) && (vcnt_q < v_live_q.act);
        hs_on  = (hcnt_x >= h_ss) && (hcnt_x < h_se);
        vs_on  = (vcnt_x >= v_ss) && (vcnt_x < v_se);
        is_sof = (hcnt_q == '0) && (vcnt_q == '0);
        is_eol = (vcnt_q < v_live_q.act) &&
                 (hcnt_x == {1'b0, h_live_q.act} - (CW+1)'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            h_live_q   <= H_INIT;
            v_live_q   <= V_INIT;
            pend_q     <= 1'b0;
            ready_q    <= 1'b0;
            seen_sof_q <= 1'b0;
            blank_q    <= 1'b1;
            hsync_q    <= ~HPOL;
            vsync_q    <= ~VPOL;
            x_q        <= '0;
            y_q        <= '0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            ready_q <= capture;
            if (capture) begin
                pend_q <= 1'b1;
            end else if (apply) begin
                pend_q <= 1'b0;
                if (cfg_ok(sh_h_q) && cfg_ok(sh_v_q)) begin
                    h_live_q <= sh_h_q;
                    v_live_q <= sh_v_q;
                end
            end
            if (enable) begin
                hcnt_q  <= hcnt_d;
                vcnt_q  <= vcnt_d;
                blank_q <= !active;
                hsync_q <= hs_on ? HPOL : ~HPOL;
                vsync_q <= vs_on ? VPOL : ~VPOL;
                x_q     <= active ? hcnt_q : '0;
                y_q     <= active ? vcnt_q : '0;
                sof_q   <= is_sof;
                eol_q   <= is_eol;
                // The very first sof after reset opens frame 0 rather than completing one.
                if (is_sof) begin
                    seen_sof_q <= 1'b1;
                    if (seen_sof_q) fcnt_q <= fcnt_q + 16'd1;
                end
            end else begin
                sof_q <= 1'b0;
                eol_q <= 1'b0;
            end
        end
    end

    // Shadow contents only matter once pend_q is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            sh_h_q <= timing_t'(cfg_h);
            sh_v_q <= timing_t'(cfg_v);
        end
    end

    assign cfg_ready = ready_q;
    assign blank     = blank_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign x         = x_q;
    assign y         = y_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small raster, active-low hsync, directed boundary cases
// followed by randomized enable/config/reset traffic against a cycle model.
module tb_video_timing_gen;

    localparam int CW = 12;
    localparam int HA = 20, HF = 4, HS = 6, HB = 5;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam bit TB_HPOL = 1'b0;
    localparam bit TB_VPOL = 1'b1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [4*CW-1:0] cfg_h = '0;
    logic [4*CW-1:0] cfg_v = '0;
    logic            cfg_ready, blank, hsync, vsync, sof, eol;
    logic [CW-1:0]   x, y;
    logic [15:0]     frame_cnt;

    video_timing_gen #(
        .CW(CW), .HACT(HA), .HFRONT(HF), .HSYNC(HS), .HBACK(HB),
        .VACT(VA), .VFRONT(VF), .VSYNC(VS), .VBACK(VB),
        .HPOL(TB_HPOL), .VPOL(TB_VPOL)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_h(cfg_h), .cfg_v(cfg_v),
        .blank(blank), .hsync(hsync), .vsync(vsync), .x(x), .y(y),
        .sof(sof), .eol(eol), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: raster position as plain integers, timing as four-field arrays.
    int              mh[4], mv[4];
    logic [4*CW-1:0] sh_h, sh_v;
    bit              pend, seen;
    int              hc, vc;
    bit              e_blank, e_hs, e_vs, e_sof, e_eol, e_ready;
    int              e_x, e_y;
    logic [15:0]     e_fc;

    function automatic int fld(input logic [4*CW-1:0] t, input int k);
        return int'(t[(3-k)*CW +: CW]);
    endfunction

    function automatic bit ok_cfg(input logic [4*CW-1:0] t);
        int tot;
        tot = fld(t, 0) + fld(t, 1) + fld(t, 2) + fld(t, 3);
        return (fld(t, 0) > 0) && (fld(t, 2) > 0) && (tot < (1 << CW));
    endfunction

    function automatic logic [4*CW-1:0] mk(input int a, input int f, input int s, input int b);
        return {CW'(a), CW'(f), CW'(s), CW'(b)};
    endfunction

    function automatic int ht();
        return mh[0] + mh[1] + mh[2] + mh[3];
    endfunction

    function automatic int vt();
        return mv[0] + mv[1] + mv[2] + mv[3];
    endfunction

    task automatic model_reset();
        mh = '{HA, HF, HS, HB};
        mv = '{VA, VF, VS, VB};
        pend = 0; seen = 0; hc = 0; vc = 0;
        e_blank = 1; e_hs = !TB_HPOL; e_vs = !TB_VPOL;
        e_x = 0; e_y = 0; e_sof = 0; e_eol = 0; e_fc = '0; e_ready = 0;
    endtask

    task automatic model_step();
        bit old_pend, wrap, act_area;
        int h_tot, v_tot;
        old_pend = pend;
        h_tot = ht();
        v_tot = vt();
        wrap = (hc == h_tot - 1) && (vc == v_tot - 1);
        e_ready = cfg_valid && !old_pend;
        if (enable) begin
            act_area = (hc < mh[0]) && (vc < mv[0]);
            e_blank = !act_area;
            e_x = act_area ? hc : 0;
            e_y = act_area ? vc : 0;
            e_hs = (hc >= mh[0] + mh[1] && hc < mh[0] + mh[1] + mh[2]) ? TB_HPOL : !TB_HPOL;
            e_vs = (vc >= mv[0] + mv[1] && vc < mv[0] + mv[1] + mv[2]) ? TB_VPOL : !TB_VPOL;
            e_sof = (hc == 0) && (vc == 0);
            e_eol = (vc < mv[0]) && (hc == mh[0] - 1);
            if (e_sof) begin
                if (seen) e_fc++;
                seen = 1;
            end
            if (wrap && old_pend) begin
                pend = 0;
                if (ok_cfg(sh_h) && ok_cfg(sh_v)) begin
                    for (int k = 0; k < 4; k++) begin
                        mh[k] = fld(sh_h, k);
                        mv[k] = fld(sh_v, k);
                    end
                end
            end
            if (hc == h_tot - 1) begin
                hc = 0;
                vc = (vc == v_tot - 1) ? 0 : vc + 1;
            end else begin
                hc++;
            end
        end else begin
            e_sof = 0;
            e_eol = 0;
        end
        if (cfg_valid && !old_pend) begin
            sh_h = cfg_h;
            sh_v = cfg_v;
            pend = 1;
        end
    endtask

    int cyc = 0, last_sof = -1, last_eol = -1, sof_period = 0, eol_period = 0;

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("blank", blank, e_blank);
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("x", x, e_x);
        chk("y", y, e_y);
        chk("sof", sof, e_sof);
        chk("eol", eol, e_eol);
        chk("frame_cnt", frame_cnt, e_fc);
        chk("cfg_ready", cfg_ready, e_ready);
        if (sof === 1'b1) begin
            if (last_sof >= 0) sof_period = cyc - last_sof;
            last_sof = cyc;
        end
        if (eol === 1'b1) begin
            if (last_eol >= 0) eol_period = cyc - last_eol;
            last_eol = cyc;
        end
    endtask

    // Called 1 time unit after a rising edge; reset is asserted and released between edges.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_blank", blank, 1);
        chk("rst_hsync", hsync, !TB_HPOL);
        chk("rst_vsync", vsync, !TB_VPOL);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_sof", sof, 0);
        chk("rst_eol", eol, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        model_reset();
        last_sof = -1;
        last_eol = -1;
        #2;
        reset = 1'b1;
    endtask

    task automatic run_until_sof();
        int g;
        g = 0;
        do begin
            tick();
            g++;
        end while (sof !== 1'b1 && g < 4000);
        chk("sof_reached", sof, 1);
    endtask

    task automatic wait_pos(input int h, input int v);
        int g;
        g = 0;
        while (!(hc == h && vc == v) && g < 4000) begin
            tick();
            g++;
        end
        chk("pos_reached", (hc == h && vc == v), 1);
    endtask

    initial begin
        int g, kind;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        enable = 1'b1;
        tick();
        chk("first_sof", sof, 1);
        chk("first_frame_cnt", frame_cnt, 0);
        run_until_sof();
        chk("sof_period_default", sof_period, 35 * 15);
        chk("frame_cnt_2nd_sof", frame_cnt, 1);

        wait_pos(0, 3);
        cfg_valid = 1'b1;
        cfg_h = mk(16, 2, 4, 3);
        cfg_v = mk(VA, VF, VS, VB);
        tick();
        chk("cfg_accept", cfg_ready, 1);
        cfg_h = mk(10, 1, 1, 1);
        repeat (5) begin
            tick();
            chk("cfg_busy", cfg_ready, 0);
        end
        cfg_valid = 1'b0;
        run_until_sof();
        chk("frame_old_timing", sof_period, 35 * 15);
        repeat (60) tick();
        chk("line_new_timing", eol_period, 25);

        wait_pos(ht() - 1, vt() - 1);
        cfg_valid = 1'b1;
        cfg_h = mk(12, 2, 3, 3);
        tick();
        chk("wrap_accept", cfg_ready, 1);
        cfg_valid = 1'b0;
        run_until_sof();
        chk("wrap_frame_a", sof_period, 25 * 15);
        run_until_sof();
        chk("wrap_frame_b", sof_period, 25 * 15);
        run_until_sof();
        chk("wrap_frame_new", sof_period, 20 * 15);

        cfg_valid = 1'b1;
        cfg_h = mk(0, 2, 3, 3);
        tick();
        chk("bad_accept", cfg_ready, 1);
        cfg_valid = 1'b0;
        run_until_sof();
        chk("bad_frame_a", sof_period, 20 * 15);
        run_until_sof();
        chk("bad_frame_b", sof_period, 20 * 15);

        repeat (7) tick();
        do_reset();
        wait_pos(5, 2);
        enable = 1'b0;
        repeat (37) tick();
        enable = 1'b1;
        g = 0;
        do begin
            tick();
            g++;
        end while (eol !== 1'b1 && g < 200);
        chk("stall_line_period", eol_period, 35 + 37);

        for (int i = 0; i < 10000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 24) == 0);
            cfg_h = mk($urandom_range(1, 24), $urandom_range(0, 6),
                       $urandom_range(1, 8), $urandom_range(0, 6));
            cfg_v = mk($urandom_range(1, 10), $urandom_range(0, 3),
                       $urandom_range(1, 3), $urandom_range(0, 4));
            kind = $urandom_range(0, 5);
            if (kind == 0) cfg_h = mk(0, 3, 4, 2);
            if (kind == 1) cfg_v = mk(6, 1, 0, 2);
            if (kind == 2) cfg_h = mk(4000, 90, 5, 10);
            tick();
            if ($urandom_range(0, 1999) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
